uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Shares the single `UART_TX` transmitter between up to `NUM_REQ` byte-stream requesters, for example the chat buffer replay, a status/echo generator and a debug dump. Arbitration is round-robin at packet granularity: a granted requester owns the transmitter until it delivers a byte flagged `req_last`. The block drives `UART_TX`'s `tx_start`/`tx_byte` pulse interface and sequences on `tx_busy`. It sits between the requesters and `UART_TX` in the chat top level.

## Interface
- `NUM_REQ`, 4: number of requesters, 1..8.
- `BUSY_TIMEOUT`, 16: cycles allowed after `tx_start` for `tx_busy` to rise before the packet is aborted.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  requester i has a byte on its lane.
- `req_byte`  in  NUM_REQ*8  packed bytes; lane i is bits [8i+7:8i].
- `req_last`  in  NUM_REQ  lane i's byte is the final byte of its packet.
- `req_ready`  out  NUM_REQ  combinational. A byte on lane i transfers on any edge where `req_valid[i] & req_ready[i]`.
- `grant`  out  NUM_REQ  one-hot current owner; all zero when idle.
- `active`  out  1  high while any owner is granted.
- `tx_start`  out  1  single-cycle start pulse to `UART_TX`.
- `tx_byte`  out  8  byte to `UART_TX`; held stable from the `tx_start` cycle until the next load.
- `tx_busy`  in  1  from `UART_TX`.
- `timeout_err`  out  1  single-cycle pulse when a packet is aborted.

## Operation
- States: IDLE, LOAD, WAIT_BUSY_HIGH, WAIT_TX.
- **IDLE**
  - If any `req_valid` is high: pick the first set bit searching upward from `last_owner+1`, wrapping modulo NUM_REQ.
  - Register `owner`, set `grant`/`active`, go to LOAD.
- **LOAD**
  - `req_ready[owner] = (state==LOAD) & !tx_busy`. All other `req_ready` bits are 0.
  - On transfer: `tx_byte <= req_byte[owner]`, `last_flag <= req_last[owner]`, `tx_start <= 1`, clear the timeout counter, go to WAIT_BUSY_HIGH.
  - With no valid byte, stay in LOAD and keep the grant. A stalled owner is never preempted.
- **WAIT_BUSY_HIGH**
  - `tx_start` returns to 0.
  - If `tx_busy` is high, go to WAIT_TX.
  - Otherwise increment the counter. When it equals `BUSY_TIMEOUT`: pulse `timeout_err`, clear `grant`/`active`, set `last_owner <= owner`, go to IDLE. The rest of that packet is the requester's problem.
- **WAIT_TX**
  - On `tx_busy==0`:
    - If `last_flag`: `last_owner <= owner`, clear `grant`/`active`, go to IDLE.
    - Otherwise go to LOAD.
- Timeout counter width is `$clog2(BUSY_TIMEOUT+1)`, saturating compare, no wrap.
- Reset values:
  - state IDLE, `last_owner = NUM_REQ-1` (so requester 0 wins first), `owner = 0`.
  - `tx_start = 0`, `tx_byte = 8'h00`, `grant = 0`, `active = 0`, `timeout_err = 0`, `req_ready = 0`.
- Boundary rules:
  - Requests arriving while a packet is in flight wait; they are not queued beyond their own `req_valid`.
  - A single-byte packet has `req_last` set on its only byte.
  - NUM_REQ=1 degenerates to a pass-through sequencer with the same timing.
  - Requests from non-owners during LOAD/WAIT states are ignored.
  - `tx_busy` already high on entry to LOAD (external or previous frame) blocks `req_ready` until it falls.
  - Reset mid-frame clears `grant` and `tx_start` immediately. The `UART_TX` in-progress frame is not aborted by this block.

## Timing
- Edge 0: `req_valid` sampled in IDLE.
- Cycle 1: LOAD, with `grant` and `req_ready` high if `tx_busy` is low.
- Edge 2: transfer. `tx_start` is high for cycle 2 only.
- Back-to-back bytes of one packet: next `req_ready` the cycle after `tx_busy` is seen low in WAIT_TX. That is 1 cycle of overhead plus the `UART_TX` frame time.
- Grant hand-off: one IDLE cycle between packets. Worst-case wait for requester i is (NUM_REQ-1) packets.
- Timeout: `timeout_err` pulses BUSY_TIMEOUT+1 cycles after the `tx_start` cycle.

## Structure
- Shared package `chat_pkg`: `arb_state_t` enum (logic [1:0]) and a `UART_BYTE_W = 8` constant.
- One sub-module, `rr_pick`: combinational round-robin priority pick with a NUM_REQ-bit request, `last_owner` in, and one-hot plus index out. It is reusable by future chat arbiters.
- All other logic is in `uart_tx_arbiter`.

## Test plan
- **Single requester, 3-byte packet.** Lane 1 sends 8'h48, 8'h69, 8'h0A (last) against a `UART_TX` model with busy for 100 cycles → exactly 3 `tx_start` pulses with those bytes in order, and `grant` = 4'b0010 throughout, then 0.
- **Fairness.** All 4 lanes request continuously with 2-byte packets → grant order is 0,1,2,3,0. No packet interleaves bytes from another lane.
- **Stall mid-packet.** Lane 2 drops `req_valid` for 50 cycles after byte 1 → `grant` stays 4'b0100, lane 0's request is held off, and transmission resumes with byte 2.
- **Busy never rises.** The model ignores `tx_start` → `timeout_err` pulses 17 cycles after `tx_start` (BUSY_TIMEOUT=16), `grant` clears, and the next lane is served.
- **Busy already high.** `tx_busy` is forced high when lane 0 requests → `req_ready` stays 0 until `tx_busy` falls, then the transfer happens the following edge.
- **Reset mid-frame.** `rst` is asserted in WAIT_TX → `tx_start`, `grant`, `active` are 0 asynchronously. After release, lane 0 is served first.

Source files
------------

// File: rtl/chat_pkg.sv
// Shared types and constants for the chat datapath arbiters.
package chat_pkg;

  localparam int unsigned UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT_BUSY_HIGH,
    ST_WAIT_TX
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first request searching upward from last_owner+1,
// wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_owner,
  output logic [NUM_REQ-1:0] pick_oh,
  output logic [IDX_W-1:0]   pick_idx,
  output logic               pick_any
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    pick_oh  = '0;
    pick_idx = '0;
    pick_any = 1'b0;
    cand     = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((32'(last_owner) + i) % NUM_REQ);
      if (!pick_any && req[cand]) begin
        pick_any      = 1'b1;
        pick_oh[cand] = 1'b1;
        pick_idx      = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin sharing of one UART_TX between NUM_REQ byte streams,
// sequenced on the transmitter's tx_start/tx_busy handshake.
module uart_tx_arbiter
  import chat_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned BUSY_TIMEOUT = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*UART_BYTE_W-1:0] req_byte,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             grant,
  output logic                           active,
  output logic                           tx_start,
  output logic [UART_BYTE_W-1:0]         tx_byte,
  input  logic                           tx_busy,
  output logic                           timeout_err
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(BUSY_TIMEOUT + 1);

  arb_state_t             state;
  logic [IDX_W-1:0]       owner;
  logic [IDX_W-1:0]       last_owner;
  logic                   last_flag;
  logic [CNT_W-1:0]       busy_cnt;
  logic [NUM_REQ-1:0]     pick_oh;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;
  logic                   xfer;
  logic [UART_BYTE_W-1:0] lane_byte [NUM_REQ];

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req        (req_valid),
    .last_owner (last_owner),
    .pick_oh    (pick_oh),
    .pick_idx   (pick_idx),
    .pick_any   (pick_any)
  );

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      lane_byte[i] = req_byte[i*UART_BYTE_W +: UART_BYTE_W];
    end
  end

  // grant is the registered one-hot of owner, so it doubles as the ready mask
  assign req_ready = (state == ST_LOAD && !tx_busy) ? grant : '0;
  assign xfer      = (state == ST_LOAD) && !tx_busy && req_valid[owner];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      owner       <= '0;
      last_owner  <= IDX_W'(NUM_REQ - 1);
      last_flag   <= 1'b0;
      busy_cnt    <= '0;
      tx_start    <= 1'b0;
      tx_byte     <= '0;
      grant       <= '0;
      active      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      tx_start    <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            owner  <= pick_idx;
            grant  <= pick_oh;
            active <= 1'b1;
            state  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (xfer) begin
            tx_byte   <= lane_byte[owner];
            last_flag <= req_last[owner];
            tx_start  <= 1'b1;
            busy_cnt  <= '0;
            state     <= ST_WAIT_BUSY_HIGH;
          end
        end
        ST_WAIT_BUSY_HIGH: begin
          if (tx_busy) begin
            state <= ST_WAIT_TX;
          end else if (busy_cnt == CNT_W'(BUSY_TIMEOUT)) begin
            timeout_err <= 1'b1;
            grant       <= '0;
            active      <= 1'b0;
            last_owner  <= owner;
            state       <= ST_IDLE;
          end else begin
            busy_cnt <= busy_cnt + 1'b1;
          end
        end
        ST_WAIT_TX: begin
          if (!tx_busy) begin
            if (last_flag) begin
              grant      <= '0;
              active     <= 1'b0;
              last_owner <= owner;
              state      <= ST_IDLE;
            end else begin
              state <= ST_LOAD;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
